// File: rtl/paddle_controller.sv
// Multi-channel paddle input controller: synchronise, debounce, rate-limit and auto-repeat
// button presses into step pulses plus a saturating position. Auto-repeat: PADDLE_AUTOREPEAT_EN.
module paddle_controller #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LOCKOUT_CYCLES  = 2500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 3000000,
  parameter int POS_WIDTH       = 10,
  parameter int POS_MAX         = 400,
  parameter int POS_INIT        = 200,
  parameter int STEP            = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           btn_up,
  input  logic [CHANNELS-1:0]           btn_down,
  output logic [CHANNELS-1:0]           up,
  output logic [CHANNELS-1:0]           down,
  output logic [CHANNELS*POS_WIDTH-1:0] pos,
  output logic [CHANNELS-1:0]           at_top,
  output logic [CHANNELS-1:0]           at_bottom
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [POS_WIDTH-1:0] POS_MAX_V  = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] POS_INIT_V = POS_WIDTH'(POS_INIT);
  localparam logic [POS_WIDTH:0]   STEP_V     = (POS_WIDTH + 1)'(STEP);

  if (DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      POS_INIT > POS_MAX) begin : g_bad_params
    $error("paddle_controller: invalid parameter set");
  end

`ifdef PADDLE_AUTOREPEAT_EN
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TM_W   = $clog2(TM_MAX + 1);
  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;
`else
  typedef enum logic {IDLE, PRESS} state_t;
`endif

  typedef enum logic [1:0] {NEUTRAL, DIR_UP, DIR_DOWN} dir_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [1:0] sync1, sync2, deb;
    dir_t       dir, cur_dir, dir_n;
    state_t     state, state_n;
    logic       pend, req, want, fire;
    logic [LK_W-1:0]      lockout;
    logic [POS_WIDTH-1:0] pos_q, pos_n;
    logic [POS_WIDTH:0]   pos_inc, pos_dec;
`ifdef PADDLE_AUTOREPEAT_EN
    logic [TM_W-1:0]      timer;
`endif

    // Bit 0 carries the up button, bit 1 the down button.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= '0;
        sync2 <= '0;
      end else begin
        sync1 <= {btn_down[ch], btn_up[ch]};
        sync2 <= sync1;
      end
    end

    for (genvar b = 0; b < 2; b++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            level;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync2[b] == level) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt   <= '0;
          level <= sync2[b];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign deb[b] = level;
    end

    always_comb begin
      case (deb)
        2'b01:   dir = DIR_UP;
        2'b10:   dir = DIR_DOWN;
        default: dir = NEUTRAL;
      endcase
    end

    // A request that meets a running lockout stays pending until the lockout reaches zero.
    always_comb begin
      state_n = state;
      dir_n   = cur_dir;
      req     = 1'b0;
      case (state)
        IDLE: begin
          if (dir != NEUTRAL) begin
            req     = 1'b1;
            state_n = PRESS;
            dir_n   = dir;
          end
        end
        default: begin
          if (dir == NEUTRAL) begin
            state_n = IDLE;
          end else if (dir != cur_dir) begin
            req     = 1'b1;
            state_n = PRESS;
            dir_n   = dir;
          end
`ifdef PADDLE_AUTOREPEAT_EN
          else if (!pend && state == PRESS && timer >= TM_W'(REPEAT_DELAY)) begin
            req     = 1'b1;
            state_n = REPEAT;
          end else if (!pend && state == REPEAT && timer >= TM_W'(REPEAT_RATE)) begin
            req = 1'b1;
          end
`endif
        end
      endcase
      want = (pend | req) & (state_n != IDLE);
      fire = want & (lockout == '0);
    end

    always_comb begin
      pos_inc = {1'b0, pos_q} + STEP_V;
      pos_dec = {1'b0, pos_q} - STEP_V;
      pos_n   = pos_q;
      if (fire && dir == DIR_UP)
        pos_n = (pos_inc > {1'b0, POS_MAX_V}) ? POS_MAX_V : pos_inc[POS_WIDTH-1:0];
      else if (fire && dir == DIR_DOWN)
        pos_n = pos_dec[POS_WIDTH] ? '0 : pos_dec[POS_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        cur_dir <= NEUTRAL;
        pend    <= 1'b0;
        lockout <= '0;
        pos_q   <= POS_INIT_V;
      end else begin
        state   <= state_n;
        cur_dir <= dir_n;
        pend    <= want & ~fire;
        pos_q   <= pos_n;
        if (fire)
          lockout <= LK_W'(LOCKOUT_CYCLES - 1);
        else if (lockout != '0)
          lockout <= lockout - 1'b1;
      end
    end

`ifdef PADDLE_AUTOREPEAT_EN
    // Counts cycles since the last emitted pulse, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        timer <= '0;
      else if (fire)
        timer <= TM_W'(1);
      else if (timer != '1)
        timer <= timer + 1'b1;
    end
`endif

    assign up[ch]        = fire & (dir == DIR_UP);
    assign down[ch]      = fire & (dir == DIR_DOWN);
    assign pos[ch*POS_WIDTH +: POS_WIDTH] = pos_q;
    assign at_top[ch]    = (pos_q == POS_MAX_V);
    assign at_bottom[ch] = (pos_q == '0);
  end

endmodule

// File: tb/tb_paddle_controller.sv
// Directed self-checking bench for paddle_controller with small timing parameters.
module tb_paddle_controller;
  localparam int CH = 2;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] btn_up = '0, btn_down = '0;
  logic [CH-1:0] up, down, at_top, at_bottom;
  logic [CH*PW-1:0] pos;
  int errors = 0;
  int checks = 0;

  paddle_controller #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(10), .REPEAT_DELAY(20),
    .REPEAT_RATE(12), .POS_WIDTH(10), .POS_MAX(40), .POS_INIT(20), .STEP(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .up(up), .down(down),
    .pos(pos), .at_top(at_top), .at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    btn_up = '0;
    btn_down = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_up = '0;
    btn_down = '0;
    #1;
    checks++; if (up !== 2'b00) begin errors++; $display("[TB] FAIL reset_up: got %b expected 00", up); end
    checks++; if (down !== 2'b00) begin errors++; $display("[TB] FAIL reset_down: got %b expected 00", down); end
    checks++; if (pos !== {10'd20, 10'd20}) begin errors++; $display("[TB] FAIL reset_pos: got %h expected %h", pos, {10'd20, 10'd20}); end
    checks++; if (at_top !== 2'b00) begin errors++; $display("[TB] FAIL reset_at_top: got %b expected 00", at_top); end
    checks++; if (at_bottom !== 2'b00) begin errors++; $display("[TB] FAIL reset_at_bottom: got %b expected 00", at_bottom); end
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (pos !== {10'd20, 10'd20} || up !== 2'b00 || down !== 2'b00) begin
      errors++; $display("[TB] FAIL idle_after_reset: got pos=%h up=%b down=%b expected pos=%h up=00 down=00", pos, up, down, {10'd20, 10'd20});
    end
  endtask

  task automatic test_single_press();
    int n = 0, at = -1, stray = 0;
    do_reset();
    btn_up = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 8) btn_up = 2'b00;
      if (up[0]) begin n++; at = k; end
      if (up[1] || down !== 2'b00) stray++;
      if (k == 6) begin
        checks++; if (pos[PW-1:0] !== 10'd20) begin errors++; $display("[TB] FAIL press_pos_before: got %0d expected 20", pos[PW-1:0]); end
      end
      if (k == 7) begin
        checks++; if (pos[PW-1:0] !== 10'd28) begin errors++; $display("[TB] FAIL press_pos_after: got %0d expected 28", pos[PW-1:0]); end
      end
    end
    checks++; if (n !== 1) begin errors++; $display("[TB] FAIL press_count: got %0d expected 1", n); end
    checks++; if (at !== 6) begin errors++; $display("[TB] FAIL press_latency: got %0d expected 6", at); end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL press_stray: got %0d expected 0", stray); end
    checks++; if (pos[2*PW-1:PW] !== 10'd20) begin errors++; $display("[TB] FAIL press_ch1_pos: got %0d expected 20", pos[2*PW-1:PW]); end
  endtask

  task automatic test_glitch();
    int n = 0;
    do_reset();
    btn_down = 2'b10;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 3) btn_down = 2'b00;
      if (up !== 2'b00 || down !== 2'b00) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", n); end
    checks++; if (pos !== {10'd20, 10'd20}) begin errors++; $display("[TB] FAIL glitch_pos: got %h expected %h", pos, {10'd20, 10'd20}); end
  endtask

  task automatic test_hold_saturate();
    int nu = 0, nd = 0;
    int ut[8];
    int dt[8];
    for (int i = 0; i < 8; i++) begin ut[i] = -1; dt[i] = -1; end
    do_reset();
    btn_up = 2'b01;
    btn_down = 2'b10;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (k == 52) begin btn_up = '0; btn_down = '0; end
      if (up[0]) begin if (nu < 8) ut[nu] = k; nu++; end
      if (down[1]) begin if (nd < 8) dt[nd] = k; nd++; end
      if (up[0] && down[0]) begin
        checks++; errors++; $display("[TB] FAIL hold_exclusive: got up=1 down=1 expected not both at cycle %0d", k);
      end
`ifdef PADDLE_AUTOREPEAT_EN
      if (k == 38) begin
        checks++; if (at_top[0] !== 1'b0 || pos[PW-1:0] !== 10'd36) begin errors++; $display("[TB] FAIL hold_pre_top: got pos=%0d top=%b expected pos=36 top=0", pos[PW-1:0], at_top[0]); end
      end
      if (k == 39) begin
        checks++; if (at_top[0] !== 1'b1 || pos[PW-1:0] !== 10'd40) begin errors++; $display("[TB] FAIL hold_top: got pos=%0d top=%b expected pos=40 top=1", pos[PW-1:0], at_top[0]); end
        checks++; if (at_bottom[1] !== 1'b1 || pos[2*PW-1:PW] !== 10'd0) begin errors++; $display("[TB] FAIL hold_bottom: got pos=%0d bottom=%b expected pos=0 bottom=1", pos[2*PW-1:PW], at_bottom[1]); end
      end
`endif
    end
`ifdef PADDLE_AUTOREPEAT_EN
    checks++; if (nu !== 4) begin errors++; $display("[TB] FAIL hold_up_count: got %0d expected 4", nu); end
    checks++; if (ut[0] !== 6 || ut[1] !== 26 || ut[2] !== 38 || ut[3] !== 50) begin
      errors++; $display("[TB] FAIL hold_up_times: got %0d,%0d,%0d,%0d expected 6,26,38,50", ut[0], ut[1], ut[2], ut[3]);
    end
    checks++; if (nd !== 4 || dt[3] !== 50) begin errors++; $display("[TB] FAIL hold_down_count: got n=%0d last=%0d expected n=4 last=50", nd, dt[3]); end
    checks++; if (pos !== {10'd0, 10'd40} || at_top !== 2'b01 || at_bottom !== 2'b10) begin
      errors++; $display("[TB] FAIL hold_final: got pos=%h top=%b bottom=%b expected pos=%h top=01 bottom=10", pos, at_top, at_bottom, {10'd0, 10'd40});
    end
`else
    checks++; if (nu !== 1 || ut[0] !== 6) begin errors++; $display("[TB] FAIL hold_single_up: got n=%0d t=%0d expected n=1 t=6", nu, ut[0]); end
    checks++; if (nd !== 1 || dt[0] !== 6) begin errors++; $display("[TB] FAIL hold_single_down: got n=%0d t=%0d expected n=1 t=6", nd, dt[0]); end
    checks++; if (pos !== {10'd12, 10'd28}) begin errors++; $display("[TB] FAIL hold_final: got %h expected %h", pos, {10'd12, 10'd28}); end
`endif
  endtask

  task automatic test_lockout();
    int ua = -1, da = -1, nu = 0, nd = 0;
    do_reset();
    btn_up = 2'b01;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 6) btn_up = 2'b00;
      if (k == 8) btn_down = 2'b01;
      if (k == 22) btn_down = 2'b00;
      if (up[0]) begin nu++; ua = k; end
      if (down[0]) begin nd++; da = k; end
      if (k == 17) begin
        checks++; if (pos[PW-1:0] !== 10'd20) begin errors++; $display("[TB] FAIL lockout_pos: got %0d expected 20", pos[PW-1:0]); end
      end
    end
    checks++; if (nu !== 1 || ua !== 6) begin errors++; $display("[TB] FAIL lockout_up: got n=%0d t=%0d expected n=1 t=6", nu, ua); end
    checks++; if (nd !== 1 || da !== 16) begin errors++; $display("[TB] FAIL lockout_down: got n=%0d t=%0d expected n=1 t=16", nd, da); end
  endtask

  task automatic test_both_pressed();
    int n = 0;
    do_reset();
    btn_up = 2'b01;
    btn_down = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (up !== 2'b00 || down !== 2'b00) n++;
    end
    btn_up = '0;
    btn_down = '0;
    repeat (10) tick();
    checks++; if (n !== 0) begin errors++; $display("[TB] FAIL both_pulses: got %0d expected 0", n); end
    checks++; if (pos[PW-1:0] !== 10'd20) begin errors++; $display("[TB] FAIL both_pos: got %0d expected 20", pos[PW-1:0]); end
  endtask

  task automatic test_reset_midpress();
    int n = 0, at = -1;
    do_reset();
    btn_up = 2'b01;
    repeat (10) tick();
    checks++; if (pos[PW-1:0] !== 10'd28) begin errors++; $display("[TB] FAIL midreset_pre_pos: got %0d expected 28", pos[PW-1:0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pos[PW-1:0] !== 10'd20 || up !== 2'b00) begin
      errors++; $display("[TB] FAIL midreset_async: got pos=%0d up=%b expected pos=20 up=00", pos[PW-1:0], up);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (up[0]) begin n++; at = k; end
    end
    checks++; if (n !== 1 || at !== 6) begin errors++; $display("[TB] FAIL midreset_repress: got n=%0d t=%0d expected n=1 t=6", n, at); end
    checks++; if (pos[PW-1:0] !== 10'd28) begin errors++; $display("[TB] FAIL midreset_pos: got %0d expected 28", pos[PW-1:0]); end
    btn_up = '0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_hold_saturate();
    test_lockout();
    test_both_pressed();
    test_reset_midpress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
